// File: rtl/my_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   NOP_INSTR     : bubble presented to decode when no instruction is valid
//   fetch_state_t : fetch FSM encoding
//   IF_ID_bus     : fields of the IF->ID pipeline register
package my_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } IF_ID_bus;

endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch FIFO holding {pc, instr} pairs between memory and decode.
//   clk, rst : clock, asynchronous active-high reset (pointers/count only)
//   push     : write wdata at the tail
//   pop      : drop the head entry
//   flush    : discard all entries (wins over push/pop)
//   wdata    : entry to write
//   head     : oldest entry (meaningful only when count != 0)
//   count    : number of entries held
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so plain pointer increments wrap mod DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_block.sv
// Instruction-fetch stage. Owns the PC, issues word requests over a
// req/gnt + rvalid memory handshake, buffers responses in an in-order
// prefetch FIFO and presents one instruction per cycle to decode.
// Redirects flush buffered and in-flight fetches.
//   CLK, RST, EN, START              : clock, async reset, stage enable, fetch enable
//   IMEM_req/addr/gnt/rvalid/rdata   : instruction memory interface
//   ID_stall                         : decode not consuming this cycle
//   BR_taken, BR_target              : redirect request and target PC
//   IF_instr, IF_pc, IF_valid        : instruction to decode (NOP/0 when invalid)
module fetch_block
  import my_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        START,
  output logic        IMEM_req,
  output logic [31:0] IMEM_addr,
  input  logic        IMEM_gnt,
  input  logic        IMEM_rvalid,
  input  logic [31:0] IMEM_rdata,
  input  logic        ID_stall,
  input  logic        BR_taken,
  input  logic [31:0] BR_target,
  output logic [31:0] IF_instr,
  output logic [31:0] IF_pc,
  output logic        IF_valid
);

  localparam int            CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_t  state;
  fetch_state_t  state_nx;
  logic [31:0]   pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   target;
  logic [CW-1:0] outst;
  logic [CW-1:0] drop;
  logic [CW-1:0] drop_nx;
  logic [CW-1:0] drop_redir;
  logic [CW-1:0] count;
  logic [63:0]   head;
  logic          accept;
  logic          rv;
  logic          redirect;
  logic          push;
  logic          pop;
  logic          nonempty;
  IF_ID_bus      if_bus;

  // Credit counts buffered plus in-flight words, so a response always has a slot.
  assign IMEM_req  = (state == RUN) && START && EN && ((count + outst) < DEPTH_C);
  assign IMEM_addr = pc;

  assign target     = BR_target & 32'hFFFF_FFFC;
  assign accept     = IMEM_req & IMEM_gnt;
  assign rv         = IMEM_rvalid & (outst != '0);
  assign redirect   = BR_taken & (state != IDLE);
  assign push       = rv & (drop == '0) & ~redirect;
  assign nonempty   = (count != '0);
  assign pop        = nonempty & ~ID_stall & EN & ~redirect;
  // Every word still owed by memory after this cycle becomes stale on a redirect.
  assign drop_redir = outst + CW'(accept) - CW'(rv);

  always_comb begin
    drop_nx = drop;
    if (redirect)                drop_nx = drop_redir;
    else if (rv && drop != '0)   drop_nx = drop - 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (START) state_nx = RUN;
      RUN: begin
        if (redirect)                    state_nx = (drop_redir != '0) ? FLUSH : RUN;
        else if (!START && outst == '0)  state_nx = IDLE;
      end
      // Leave FLUSH on the edge that retires the last stale word so the
      // first target request issues in the following cycle.
      FLUSH:   if (drop_nx == '0) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // rsp_pc is the PC of the next response that will be kept: requests are
  // contiguous between redirects and responses return in order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      rsp_pc <= RESET_PC;
      outst  <= '0;
      drop   <= '0;
    end else begin
      state <= state_nx;
      drop  <= drop_nx;
      outst <= outst + CW'(accept) - CW'(rv);
      if (redirect) begin
        pc     <= target;
        rsp_pc <= target;
      end else begin
        if (accept) pc     <= pc + 32'd4;
        if (push)   rsp_pc <= rsp_pc + 32'd4;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({rsp_pc, IMEM_rdata}),
    .head  (head),
    .count (count)
  );

  always_comb begin
    if_bus.valid = nonempty;
    if_bus.pc    = nonempty ? head[63:32] : 32'h0;
    if_bus.instr = nonempty ? head[31:0]  : NOP_INSTR;
  end

  assign IF_valid = if_bus.valid;
  assign IF_pc    = if_bus.pc;
  assign IF_instr = if_bus.instr;

  // Memory shares RST, so rvalid is low whenever outst was just cleared.
  always @(posedge CLK) begin
    assert (!(IMEM_rvalid && outst == '0));
  end

endmodule

// File: tb/tb_fetch_block.sv
module tb_fetch_block;
  import my_pkg::*;

  localparam logic [31:0] RPC   = 32'hFFFF_FFF8;
  localparam int          DEPTH = 2;

  logic        CLK = 1'b0;
  logic        RST, EN, START, IMEM_gnt, IMEM_rvalid, ID_stall, BR_taken;
  logic        IMEM_req, IF_valid;
  logic [31:0] IMEM_addr, IMEM_rdata, BR_target, IF_instr, IF_pc;

  fetch_block #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .START(START),
    .IMEM_req(IMEM_req), .IMEM_addr(IMEM_addr), .IMEM_gnt(IMEM_gnt),
    .IMEM_rvalid(IMEM_rvalid), .IMEM_rdata(IMEM_rdata),
    .ID_stall(ID_stall), .BR_taken(BR_taken), .BR_target(BR_target),
    .IF_instr(IF_instr), .IF_pc(IF_pc), .IF_valid(IF_valid)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } rsp_t;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [63:0] sb[$];      // expected {pc, instr} in decode order
  rsp_t        mq[$];      // memory responses owed
  int          cyc_n  = 0;
  int          lat    = 1;
  logic        gnt_en = 1'b0;
  logic [31:0] exp_pc;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Memory side for the current cycle, then let combinational outputs settle.
  task automatic step_a();
    IMEM_gnt    = gnt_en;
    IMEM_rvalid = 1'b0;
    IMEM_rdata  = 32'h0;
    if (mq.size() > 0 && mq[0].due <= cyc_n) begin
      IMEM_rvalid = 1'b1;
      IMEM_rdata  = mq[0].addr ^ 32'hA5A5_0000;
      void'(mq.pop_front());
    end
    #1;
  endtask

  // Account for a grant and/or redirect in this cycle, then advance.
  task automatic step_b();
    if (IMEM_req && IMEM_gnt) begin
      check32("imem_addr", IMEM_addr, exp_pc);
      mq.push_back('{cyc_n + lat, IMEM_addr});
      if (!BR_taken) sb.push_back({exp_pc, exp_pc ^ 32'hA5A5_0000});
      exp_pc += 32'd4;
    end
    if (BR_taken) begin
      sb.delete();
      exp_pc = BR_target & 32'hFFFF_FFFC;
    end
    @(negedge CLK);
    cyc_n++;
  endtask

  task automatic run(input int n, input logic st, input logic en, input logic stall);
    for (int i = 0; i < n; i++) begin
      START = st; EN = en; ID_stall = stall; BR_taken = 1'b0;
      step_a();
      step_b();
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; START = 1'b0; EN = 1'b0; ID_stall = 1'b0; BR_taken = 1'b0;
    BR_target = 32'h0; IMEM_gnt = 1'b0; IMEM_rvalid = 1'b0; IMEM_rdata = 32'h0;
    mq.delete(); sb.delete(); exp_pc = RPC;
    #1;
    check32("rst_req",    {31'b0, IMEM_req}, 32'h0);
    check32("rst_addr",   IMEM_addr, 32'hFFFF_FFF8);
    check32("rst_valid",  {31'b0, IF_valid}, 32'h0);
    check32("rst_instr",  IF_instr, 32'h0000_0013);
    check32("rst_pc",     IF_pc, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Scoreboard monitor: consumes an expected entry whenever decode takes one.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge CLK);
      #2;
      if (RST !== 1'b1) begin
        if (IF_valid) begin
          if (!ID_stall && EN && !BR_taken) begin
            if (sb.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL extra_instr: got pc %h, required no instruction", IF_pc);
            end else begin
              e = sb.pop_front();
              check32("if_pc",    IF_pc,    e[63:32]);
              check32("if_instr", IF_instr, e[31:0]);
            end
          end
        end else begin
          check32("bubble_instr", IF_instr, NOP_INSTR);
          check32("bubble_pc",    IF_pc,    32'h0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Streaming from RESET_PC: FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap), ...
    gnt_en = 1'b1; lat = 1;
    run(12, 1'b1, 1'b1, 1'b0);

    // Decode stall for 5 cycles: buffer fills, requests stop.
    run(4, 1'b1, 1'b1, 1'b1);
    START = 1'b1; EN = 1'b1; ID_stall = 1'b1; BR_taken = 1'b0;
    step_a();
    check32("stall_req",   {31'b0, IMEM_req}, 32'h0);
    check32("stall_valid", {31'b0, IF_valid}, 32'h1);
    step_b();
    run(10, 1'b1, 1'b1, 1'b0);

    // Redirect to 0x100 with two requests outstanding.
    run(8, 1'b0, 1'b1, 1'b0);
    lat = 3;
    run(3, 1'b1, 1'b1, 1'b0);
    BR_taken = 1'b1; BR_target = 32'h0000_0100;
    step_a();
    check32("br1_req_blocked", {31'b0, IMEM_req}, 32'h0);
    step_b();
    BR_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step_a();
      check32("flush_req", {31'b0, IMEM_req}, 32'h0);
      step_b();
    end
    step_a();
    check32("br1_req",  {31'b0, IMEM_req}, 32'h1);
    check32("br1_addr", IMEM_addr, 32'h0000_0100);
    step_b();
    run(12, 1'b1, 1'b1, 1'b0);

    // Redirect to 0x203 in the same cycle as a grant and a response.
    run(10, 1'b0, 1'b1, 1'b0);
    lat = 1;
    run(2, 1'b1, 1'b1, 1'b0);
    BR_taken = 1'b1; BR_target = 32'h0000_0203;
    step_a();
    check32("br2_req",    {31'b0, IMEM_req},    32'h1);
    check32("br2_rvalid", {31'b0, IMEM_rvalid}, 32'h1);
    step_b();
    BR_taken = 1'b0;
    step_a();
    check32("br2_no_stale", {31'b0, IF_valid}, 32'h0);
    check32("br2_flush_req", {31'b0, IMEM_req}, 32'h0);
    step_b();
    step_a();
    check32("br2_req_tgt", {31'b0, IMEM_req}, 32'h1);
    check32("br2_addr",    IMEM_addr, 32'h0000_0200);
    step_b();
    run(12, 1'b1, 1'b1, 1'b0);

    // Redirect with nothing outstanding: target requested next cycle.
    run(10, 1'b0, 1'b1, 1'b0);
    gnt_en = 1'b0;
    run(3, 1'b1, 1'b1, 1'b0);
    BR_taken = 1'b1; BR_target = 32'h0000_0040;
    step_a();
    step_b();
    BR_taken = 1'b0; gnt_en = 1'b1;
    step_a();
    check32("br3_req",  {31'b0, IMEM_req}, 32'h1);
    check32("br3_addr", IMEM_addr, 32'h0000_0040);
    step_b();
    run(8, 1'b1, 1'b1, 1'b0);

    // Reset mid-burst, then one response arriving while EN is low.
    do_reset();
    lat = 2; gnt_en = 1'b1;
    run(2, 1'b1, 1'b1, 1'b0);
    run(2, 1'b1, 1'b0, 1'b0);
    START = 1'b1; EN = 1'b0; ID_stall = 1'b0; BR_taken = 1'b0;
    step_a();
    check32("en0_valid", {31'b0, IF_valid}, 32'h1);
    check32("en0_pc",    IF_pc,    32'hFFFF_FFF8);
    check32("en0_instr", IF_instr, 32'h5A5A_FFF8);
    check32("en0_req",   {31'b0, IMEM_req}, 32'h0);
    step_b();
    run(1, 1'b1, 1'b0, 1'b0);
    run(6, 1'b0, 1'b1, 1'b0);

    check32("sb_drained", sb.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
